address_bus_low: RTL and testbench

- Low-byte address generator of the 65C02 datapath.
- Forms the combinational low address byte ADL as an 8-bit add of two selected sources plus carry-in.
- Holds the registered address-low (ABL), the program-counter low byte (PCL) and an auxiliary hold latch (AHL).
- Exports the adder carry (CO) and the PCL increment carry (pcl_co) to the address-high block.

---
 rtl/address_bus_low_pkg.sv | 22 ++
 rtl/address_bus_low_pc_byte.sv | 29 ++
 rtl/address_bus_low.sv | 80 ++++++++
 tb/tb_address_bus_low.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/address_bus_low_pkg.sv
// Shared definitions for the 65C02 low address byte datapath.
// Operand select codes and op-field bit positions.
package address_bus_low_pkg;

  localparam int unsigned OP_A_HI = 4;
  localparam int unsigned OP_A_LO = 2;
  localparam int unsigned OP_B_HI = 1;
  localparam int unsigned OP_B_LO = 0;

  localparam logic [2:0] SRC_ABL  = 3'd0;
  localparam logic [2:0] SRC_PCL  = 3'd1;
  localparam logic [2:0] SRC_DB   = 3'd2;
  localparam logic [2:0] SRC_AHL  = 3'd3;
  localparam logic [2:0] SRC_REG  = 3'd4;
  localparam logic [2:0] SRC_ZERO = 3'd5;

  localparam logic [1:0] B_ZERO = 2'd0;
  localparam logic [1:0] B_REG  = 2'd1;
  localparam logic [1:0] B_DB   = 2'd2;
  localparam logic [1:0] B_AHL  = 2'd3;

endpackage

// File: rtl/address_bus_low_pc_byte.sv
// One program-counter byte: load/increment register with wrap carry.
// Shared with the high-byte block, which chains on co.
module pc_byte (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       inc,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic       co
);

  logic [7:0] base;
  logic [8:0] sum;

  // With neither ld nor inc, base=q and inc=0, so the register holds.
  always_comb begin
    base = ld ? din : q;
    sum  = {1'b0, base} + {8'b0, inc};
  end

  assign co = sum[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 8'h00;
    else     q <= sum[7:0];
  end

endmodule

// File: rtl/address_bus_low.sv
// 65C02 low address byte: operand muxes, 8-bit adder, ABL/AHL regs
// and the PCL byte.
module address_bus_low
  import address_bus_low_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic [4:0] op,
  input  logic       CI,
  output logic       CO,
  input  logic       ld_ahl,
  input  logic       ld_pc,
  input  logic       inc_pc,
  output logic       pcl_co,
  output logic [7:0] PCL,
  output logic [7:0] ADL,
  input  logic [7:0] DB,
  input  logic [7:0] REG
);

  logic [2:0] a_sel;
  logic [1:0] b_sel;
  logic [7:0] a_src;
  logic [7:0] b_src;
  logic [7:0] abl;
  logic [7:0] ahl;
  logic [8:0] sum;

  assign a_sel = op[OP_A_HI:OP_A_LO];
  assign b_sel = op[OP_B_HI:OP_B_LO];

  always_comb begin
    a_src = 8'h00;
    unique case (1'b1)
      (a_sel == SRC_ABL):  a_src = abl;
      (a_sel == SRC_PCL):  a_src = PCL;
      (a_sel == SRC_DB):   a_src = DB;
      (a_sel == SRC_AHL):  a_src = ahl;
      (a_sel == SRC_REG):  a_src = REG;
      (a_sel >= SRC_ZERO): a_src = 8'h00;
      default:             a_src = 8'h00;
    endcase
  end

  always_comb begin
    b_src = 8'h00;
    unique case (1'b1)
      (b_sel == B_ZERO): b_src = 8'h00;
      (b_sel == B_REG):  b_src = REG;
      (b_sel == B_DB):   b_src = DB;
      (b_sel == B_AHL):  b_src = ahl;
      default:           b_src = 8'h00;
    endcase
  end

  assign sum = {1'b0, a_src} + {1'b0, b_src} + {8'b0, CI};
  assign ADL = sum[7:0];
  assign CO  = sum[8];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      abl <= 8'h00;
      ahl <= 8'h00;
    end else begin
      abl <= ADL;
      if (ld_ahl) ahl <= DB;
    end
  end

  pc_byte u_pcl (
    .clk (clk),
    .rst (RST),
    .ld  (ld_pc),
    .inc (inc_pc),
    .din (ADL),
    .q   (PCL),
    .co  (pcl_co)
  );

endmodule

// File: tb/tb_address_bus_low.sv
// Scoreboard bench for address_bus_low against an arithmetic model.
// Directed plan followed by randomized cycles with sporadic resets.
module tb_address_bus_low;

  typedef struct {
    string      tag;
    logic [7:0] adl;
    logic       co;
    logic [7:0] pcl;
    logic       pcl_co;
  } exp_t;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] op = 5'b10100;
  logic       CI = 1'b0;
  logic       CO;
  logic       ld_ahl = 1'b0;
  logic       ld_pc = 1'b0;
  logic       inc_pc = 1'b0;
  logic       pcl_co;
  logic [7:0] PCL;
  logic [7:0] ADL;
  logic [7:0] DB = 8'h00;
  logic [7:0] REG = 8'h00;

  int checks = 0;
  int passes = 0;
  exp_t sb[$];

  int m_abl = 0;
  int m_pcl = 0;
  int m_ahl = 0;
  int m_adl = 0;

  address_bus_low dut (
    .clk    (clk),
    .RST    (RST),
    .op     (op),
    .CI     (CI),
    .CO     (CO),
    .ld_ahl (ld_ahl),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .pcl_co (pcl_co),
    .PCL    (PCL),
    .ADL    (ADL),
    .DB     (DB),
    .REG    (REG)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, string f, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s.%s actual=%0h required=%0h t=%0t",
                  tag, f, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "ADL", int'(ADL), int'(e.adl));
      chk(e.tag, "CO", int'(CO), int'(e.co));
      chk(e.tag, "PCL", int'(PCL), int'(e.pcl));
      chk(e.tag, "pcl_co", int'(pcl_co), int'(e.pcl_co));
    end
  end

  // Reference model: operand table lookup and plain integer sums.
  task automatic expect_now(string tag);
    int a_tab[8];
    int b_tab[4];
    int s;
    int pc_sum;
    exp_t e;
    a_tab = '{m_abl, m_pcl, int'(DB), m_ahl, int'(REG), 0, 0, 0};
    b_tab = '{0, int'(REG), int'(DB), m_ahl};
    s = a_tab[op[4:2]] + b_tab[op[1:0]] + int'(CI);
    m_adl = s % 256;
    pc_sum = (ld_pc ? m_adl : m_pcl) + int'(inc_pc);
    e.tag = tag;
    e.adl = 8'(m_adl);
    e.co = (s > 255);
    e.pcl = 8'(m_pcl);
    e.pcl_co = (pc_sum > 255);
    sb.push_back(e);
  endtask

  task automatic commit();
    m_abl = m_adl;
    if (ld_ahl) m_ahl = int'(DB);
    m_pcl = ((ld_pc ? m_adl : m_pcl) + int'(inc_pc)) % 256;
  endtask

  task automatic step(string tag, logic [4:0] o, logic c,
                      logic [7:0] d, logic [7:0] r,
                      logic la, logic lp, logic ip);
    op = o; CI = c; DB = d; REG = r;
    ld_ahl = la; ld_pc = lp; inc_pc = ip;
    expect_now(tag);
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic do_reset(string tag);
    RST = 1'b1;
    m_abl = 0; m_pcl = 0; m_ahl = 0;
    expect_now(tag);
    @(negedge clk);
    #1 RST = 1'b0;
    @(posedge clk);
    commit();
    #1;
  endtask

  initial begin
    do_reset("reset");
    step("abl_after_rst", 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0);
    step("idx_add", 5'b01001, 0, 8'hF0, 8'h20, 0, 0, 0);
    step("abl_hold1", 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0);
    step("abl_hold2", 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0);
    step("ahl_load", 5'b01100, 0, 8'h34, 8'h00, 1, 0, 0);
    step("ahl_use", 5'b01100, 1, 8'h00, 8'h00, 0, 0, 0);
    step("pc_ld_inc", 5'b01000, 0, 8'hFF, 8'h00, 0, 1, 1);
    step("pc_ld_fe", 5'b01000, 0, 8'hFE, 8'h00, 0, 1, 0);
    step("pc_inc_fe", 5'b00000, 0, 8'h00, 8'h00, 0, 0, 1);
    step("pc_inc_ff", 5'b00000, 0, 8'h00, 8'h00, 0, 0, 1);
    step("pc_hold", 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0);
    step("pc_ld_7f", 5'b01000, 0, 8'h7F, 8'h00, 0, 1, 0);
    step("pc_at_7f", 5'b00100, 0, 8'h00, 8'h00, 0, 0, 1);
    do_reset("mid_reset");
    step("pc_after_rst", 5'b00100, 0, 8'h00, 8'h00, 0, 0, 1);
    step("reserved_a", 5'b11110, 1, 8'h55, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        op = 5'($urandom);
        inc_pc = 1'($urandom);
        ld_pc = 1'($urandom);
        do_reset("rnd_reset");
      end else begin
        step("rnd", 5'($urandom), 1'($urandom), 8'($urandom),
             8'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
      end
    end
    @(negedge clk);
    #1;
    chk("end", "sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
